clk_freq_mon: RTL and testbench
===============================

// Module: clk_freq_mon
// PURPOSE
//  Multi-channel clock frequency monitor, successor to the single-xclk fail-safe check in the clock/reset manager.
//  Counts synchronised rising edges of NCH asynchronous monitored clocks over a fixed window of reference cycles.
//  Flags a channel as failed after FAIL_CNT consecutive windows whose edge count falls outside [lo_th, hi_th].
//  Sits in the ROSC 128MHz domain; fail status feeds the system reset combiner.
// PARAMETERS
//  NCH         2  number of monitored clock channels (1..8)
//  WIN_W       9  window length = 2**WIN_W reference cycles
//  CNT_W       9  edge counter / threshold width; counter saturates at 2**CNT_W-1
//  SYNC_STAGES 2  synchroniser flops per channel before the edge-detect flop (>=2)
//  FAIL_CNT    2  consecutive bad windows required to set fail (1..15)
// PORTS
//  clk      in  1          reference clock (ROSC 128MHz)
//  rst      in  1          asynchronous reset, active-high
//  mon_clk  in  NCH        monitored clocks, asynchronous to clk
//  en       in  NCH        per-channel monitor enable (level)
//  lo_th    in  NCH*CNT_W  per-channel minimum edges per window; ch i at [i*CNT_W +: CNT_W]
//  hi_th    in  NCH*CNT_W  per-channel maximum edges per window
//  fail_clr in  NCH        single-cycle pulse: clears sticky fail[i]
//  cnt_out  out NCH*CNT_W  edge count of the last completed window
//  cnt_vld  out 1          1-cycle pulse: cnt_out updated
//  fail     out NCH        sticky per-channel fail
//  fail_any out 1          registered OR of fail
//  rst_req  out 1          reset request (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: all flops 0; cnt_out=0, cnt_vld=0, fail=0, fail_any=0, rst_req=0, warm-up flag=1.
//  - Window counter: WIN_W bits, free-running, wraps; window end (WE) = counter all-ones.
//  - Per channel: SYNC_STAGES sync flops + 1 edge flop; edge = sync_last & ~edge_flop.
//    Latency from mon_clk rise to count increment: SYNC_STAGES+1 clk cycles.
//  - Edge counter: increments on edge, saturates at 2**CNT_W-1 (no wrap).
//  - On WE: cnt_out <= counter value including any edge in the WE cycle; counter <= 0; cnt_vld=1 next cycle.
//  - Evaluation at WE (ch i): bad = en[i] & ~warmup & (cnt < lo_th[i] | cnt > hi_th[i]); thresholds sampled at WE only.
//    bad: bad_cnt[i] increments, saturating at FAIL_CNT; reaching FAIL_CNT sets fail[i].
//    good, or en[i]=0: bad_cnt[i] <= 0. fail[i] stays set regardless (sticky).
//  - Warm-up: first window after reset is counted and reported (cnt_vld fires) but never evaluated;
//    warm-up clears at the first WE.
//  - fail_clr[i] clears fail[i] and bad_cnt[i]; if set and clear hit the same cycle, set wins.
//  - lo_th > hi_th: every enabled window is bad (legal, no special case).
//  - fail_any: registered OR of fail, 1 cycle behind fail.
//  - Async rst mid-window: all state discarded; the window restarts with warm-up.
// CONFIGURATION
//  CLK_FREQ_MON_RST_REQ_EN defined:
//    rst_req <= |(fail & en), registered; deasserts 1 cycle after fail_clr or en drop.
//  Not defined:
//    rst_req tied 0; no extra flops; fail/fail_any unchanged.
// TESTING (NCH=2, WIN_W=8, CNT_W=9, SYNC_STAGES=2, FAIL_CNT=2, lo=24, hi=40)
//  1. mon_clk[0]=clk/8, en=01 -> cnt_out[0]=32 every 256 cycles, cnt_vld pulses, fail=00.
//  2. mon_clk[0] stopped after window 3 -> window 4 partial count 0 <24 (bad 1), window 5 bad 2
//     -> fail[0]=1 one cycle after WE5, fail_any one cycle later.
//  3. mon_clk[1]=clk/4 (64 edges), en=10 -> fail[1] after 2 windows; en=00 -> never fails.
//  4. fail[0]=1, pulse fail_clr[0] in a WE cycle that is the 2nd bad window -> fail[0] stays 1;
//     clear in a non-WE cycle -> fail[0]=0.
//  5. mon_clk=clk/2, CNT_W=6 -> counter saturates at 63, cnt_out=63, no wrap.
//  6. Assert rst for 3 cycles mid-window -> all outputs 0; first window not evaluated;
//     with CLK_FREQ_MON_RST_REQ_EN, rst_req tracks fail&en.

Source files
------------

// File: rtl/clk_freq_mon.sv
// Multi-channel clock frequency monitor.
// Counts synchronised rising edges of NCH asynchronous clocks over a window of
// 2**WIN_W reference cycles and flags a channel after FAIL_CNT consecutive
// out-of-range windows. The first window after reset is reported but not judged.
// Optional feature: define CLK_FREQ_MON_RST_REQ_EN to drive rst_req from the
// enabled fail flags; otherwise rst_req is tied low.
module clk_freq_mon #(
  parameter int unsigned NCH         = 2,
  parameter int unsigned WIN_W       = 9,
  parameter int unsigned CNT_W       = 9,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FAIL_CNT    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       mon_clk,
  input  logic [NCH-1:0]       en,
  input  logic [NCH*CNT_W-1:0] lo_th,
  input  logic [NCH*CNT_W-1:0] hi_th,
  input  logic [NCH-1:0]       fail_clr,
  output logic [NCH*CNT_W-1:0] cnt_out,
  output logic                 cnt_vld,
  output logic [NCH-1:0]       fail,
  output logic                 fail_any,
  output logic                 rst_req
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [3:0]       FAIL_LIM = 4'(FAIL_CNT);

  logic [WIN_W-1:0]                   win_cnt;
  logic                               we;
  logic                               warmup;
  logic [NCH-1:0][SYNC_STAGES-1:0]    sync_q;
  logic [NCH-1:0]                     edge_q;
  logic [NCH-1:0][CNT_W-1:0]          edge_cnt;
  logic [NCH-1:0][CNT_W-1:0]          cnt_fin;
  logic [NCH-1:0][CNT_W-1:0]          lo_v;
  logic [NCH-1:0][CNT_W-1:0]          hi_v;
  logic [NCH-1:0][3:0]                bad_cnt;
  logic [NCH-1:0][3:0]                bad_nxt;
  logic [NCH-1:0]                     fail_set;

  assign we   = &win_cnt;
  assign lo_v = lo_th;
  assign hi_v = hi_th;

  // free-running window timer; warm-up ends at the first window end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_cnt <= '0;
      warmup  <= 1'b1;
    end else begin
      win_cnt <= win_cnt + WIN_W'(1);
      if (we) warmup <= 1'b0;
    end
  end

  // per-channel synchroniser chain followed by the edge-detect flop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      edge_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], mon_clk[i]};
        edge_q[i] <= sync_q[i][SYNC_STAGES-1];
      end
    end
  end

  // saturating count including this cycle's edge, and window-end judgement
  always_comb begin
    cnt_fin  = edge_cnt;
    bad_nxt  = bad_cnt;
    fail_set = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (sync_q[i][SYNC_STAGES-1] && !edge_q[i] && edge_cnt[i] != CNT_MAX)
        cnt_fin[i] = edge_cnt[i] + CNT_W'(1);
      if (we) begin
        if (en[i] && !warmup && (cnt_fin[i] < lo_v[i] || cnt_fin[i] > hi_v[i])) begin
          bad_nxt[i]  = (bad_cnt[i] >= FAIL_LIM) ? FAIL_LIM : bad_cnt[i] + 4'd1;
          fail_set[i] = (bad_nxt[i] == FAIL_LIM);
        end else begin
          bad_nxt[i] = '0;
        end
      end
      // a clear loses to a simultaneous set, and then leaves the streak intact
      if (fail_clr[i] && !fail_set[i]) bad_nxt[i] = '0;
    end
  end

  // edge counters, window report, bad-window streaks and sticky fail flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_cnt <= '0;
      bad_cnt  <= '0;
      cnt_out  <= '0;
      cnt_vld  <= 1'b0;
      fail     <= '0;
    end else begin
      edge_cnt <= we ? '0 : cnt_fin;
      bad_cnt  <= bad_nxt;
      cnt_vld  <= we;
      if (we) cnt_out <= cnt_fin;
      fail <= fail_set | (fail & ~fail_clr);
    end
  end

  // summary flag, one cycle behind the per-channel flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fail_any <= 1'b0;
    else     fail_any <= |fail;
  end

`ifdef CLK_FREQ_MON_RST_REQ_EN
  // reset request follows failed channels that are still enabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rst_req <= 1'b0;
    else     rst_req <= |(fail & en);
  end
`else
  assign rst_req = 1'b0;
`endif

endmodule

// File: tb/tb_clk_freq_mon.sv
// Bench for clk_freq_mon: table of per-window vectors, hand-written corner
// sequences, and a randomized phase checked against a window/latency model.
`timescale 1ns/1ps
module tb_clk_freq_mon;
  localparam int unsigned NCH   = 2;
  localparam int unsigned WIN_W = 8;
  localparam int unsigned CNT_W = 9;
  localparam int unsigned SS    = 2;
  localparam int unsigned FC    = 2;
  localparam int unsigned WIN   = 1 << WIN_W;
  localparam int unsigned CMAX  = (1 << CNT_W) - 1;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NCH-1:0]       mon_clk = '0;
  logic [NCH-1:0]       en = '0;
  logic [NCH-1:0]       fail_clr = '0;
  logic [NCH*CNT_W-1:0] lo_th = '0;
  logic [NCH*CNT_W-1:0] hi_th = '0;
  logic [NCH*CNT_W-1:0] cnt_out;
  logic                 cnt_vld, fail_any, rst_req;
  logic [NCH-1:0]       fail;

  logic       s_mon = 1'b0;
  logic [5:0] s_cnt;
  logic       s_vld, s_any, s_rreq;
  logic [0:0] s_fail;

  clk_freq_mon #(.NCH(NCH), .WIN_W(WIN_W), .CNT_W(CNT_W), .SYNC_STAGES(SS), .FAIL_CNT(FC)) dut (
    .clk(clk), .rst(rst), .mon_clk(mon_clk), .en(en), .lo_th(lo_th), .hi_th(hi_th),
    .fail_clr(fail_clr), .cnt_out(cnt_out), .cnt_vld(cnt_vld), .fail(fail),
    .fail_any(fail_any), .rst_req(rst_req));

  clk_freq_mon #(.NCH(1), .WIN_W(WIN_W), .CNT_W(6), .SYNC_STAGES(SS), .FAIL_CNT(FC)) dut_sat (
    .clk(clk), .rst(rst), .mon_clk(s_mon), .en(1'b1), .lo_th(6'd0), .hi_th(6'd63),
    .fail_clr(1'b0), .cnt_out(s_cnt), .cnt_vld(s_vld), .fail(s_fail),
    .fail_any(s_any), .rst_req(s_rreq));

  always #5 clk = ~clk;

  // monitored clocks: half period in clk cycles, 0 = stopped low
  int unsigned half [NCH];
  int unsigned ph   [NCH];
  always @(negedge clk) begin
    s_mon <= ~s_mon;
    for (int i = 0; i < NCH; i++) begin
      if (half[i] == 0) begin
        mon_clk[i] <= 1'b0;
        ph[i]      <= 0;
      end else if (ph[i] + 1 >= half[i]) begin
        mon_clk[i] <= ~mon_clk[i];
        ph[i]      <= 0;
      end else begin
        ph[i] <= ph[i] + 1;
      end
    end
  end

  // reference model: rises sampled on clk land SS cycles later; windows are
  // every WIN cycles after reset release
  int unsigned    cyc;
  logic [NCH-1:0] m_prev, m_fail, m_old, m_set;
  int unsigned    m_due [NCH][$];
  int unsigned    m_cnt [NCH];
  int unsigned    m_bad [NCH];
  int unsigned    m_rep [NCH];
  logic           m_warm, m_vld, m_any, m_rreq, m_we;
  int unsigned    m_lo, m_hi;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      cyc = 0; m_prev = '0; m_fail = '0; m_warm = 1'b1;
      m_vld = 1'b0; m_any = 1'b0; m_rreq = 1'b0;
      for (int i = 0; i < NCH; i++) begin
        m_due[i].delete(); m_cnt[i] = 0; m_bad[i] = 0; m_rep[i] = 0;
      end
    end else begin
      m_old = m_fail;
      cyc   = cyc + 1;
      m_we  = (cyc % WIN) == 0;
      m_set = '0;
      for (int i = 0; i < NCH; i++) begin
        while (m_due[i].size() > 0 && m_due[i][0] == cyc) begin
          void'(m_due[i].pop_front());
          if (m_cnt[i] < CMAX) m_cnt[i] = m_cnt[i] + 1;
        end
        if (mon_clk[i] && !m_prev[i]) m_due[i].push_back(cyc + SS);
        m_prev[i] = mon_clk[i];
        if (m_we) begin
          m_rep[i] = m_cnt[i];
          m_cnt[i] = 0;
          m_lo = int'(lo_th[i*CNT_W +: CNT_W]);
          m_hi = int'(hi_th[i*CNT_W +: CNT_W]);
          if (en[i] && !m_warm && (m_rep[i] < m_lo || m_rep[i] > m_hi)) begin
            m_bad[i] = (m_bad[i] + 1 > FC) ? FC : m_bad[i] + 1;
            m_set[i] = (m_bad[i] == FC);
          end else begin
            m_bad[i] = 0;
          end
        end
        if (m_set[i]) m_fail[i] = 1'b1;
        else if (fail_clr[i]) begin m_fail[i] = 1'b0; m_bad[i] = 0; end
      end
      if (m_we) m_warm = 1'b0;
      m_vld = m_we;
      m_any = |m_old;
`ifdef CLK_FREQ_MON_RST_REQ_EN
      m_rreq = |(m_old & en);
`else
      m_rreq = 1'b0;
`endif
    end
  end

  int unsigned n_tot = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cyc %0d: got %0h want %0h", name, cyc, act, exp);
    end
  endtask

  task automatic to_cyc(input int unsigned c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic do_reset(input int unsigned n);
    rst = 1'b1;
    #1;
    chk("rst cnt_out", cnt_out, 0);
    chk("rst cnt_vld", cnt_vld, 0);
    chk("rst fail", fail, 0);
    chk("rst fail_any", fail_any, 0);
    chk("rst rst_req", rst_req, 0);
    chk("rst sat cnt", s_cnt, 0);
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_th(input int unsigned l0, h0, l1, h1);
    lo_th = {9'(l1), 9'(l0)};
    hi_th = {9'(h1), 9'(h0)};
  endtask

  typedef struct {
    logic [1:0]  en;
    int unsigned lo0, hi0, lo1, hi1;
    logic [1:0]  clr;
    logic        chk_cnt;
    int unsigned c0, c1;
    logic [1:0]  fl;
  } vec_t;
  vec_t tbl [13];

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not finish, got timeout want finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{2'b11, 24, 40, 24, 40, 2'b00, 1'b0,  0,  0, 2'b00};
    tbl[1]  = '{2'b11, 24, 40, 24, 40, 2'b00, 1'b1, 32, 64, 2'b00};
    tbl[2]  = '{2'b11, 24, 40, 24, 40, 2'b00, 1'b1, 32, 64, 2'b10};
    tbl[3]  = '{2'b11, 24, 40, 24, 40, 2'b10, 1'b1, 32, 64, 2'b00};
    tbl[4]  = '{2'b01, 24, 40, 24, 40, 2'b00, 1'b1, 32, 64, 2'b00};
    tbl[5]  = '{2'b11, 24, 40, 24, 40, 2'b00, 1'b1, 32, 64, 2'b00};
    tbl[6]  = '{2'b11, 40, 30, 60, 70, 2'b00, 1'b1, 32, 64, 2'b00};
    tbl[7]  = '{2'b11, 40, 30, 60, 70, 2'b00, 1'b1, 32, 64, 2'b01};
    tbl[8]  = '{2'b00, 24, 40, 24, 40, 2'b00, 1'b1, 32, 64, 2'b01};
    tbl[9]  = '{2'b11, 24, 40, 24, 40, 2'b01, 1'b1, 32, 64, 2'b00};
    tbl[10] = '{2'b11, 32, 32, 64, 64, 2'b00, 1'b1, 32, 64, 2'b00};
    tbl[11] = '{2'b11, 33, 40,  0, 63, 2'b00, 1'b1, 32, 64, 2'b00};
    tbl[12] = '{2'b11, 33, 40,  0, 63, 2'b00, 1'b1, 32, 64, 2'b11};

    // table: ch0 = clk/8 (32 edges), ch1 = clk/4 (64 edges) per window
    half[0] = 4; half[1] = 2;
    @(negedge clk);
    do_reset(3);
    for (int r = 0; r < 13; r++) begin
      en = tbl[r].en;
      set_th(tbl[r].lo0, tbl[r].hi0, tbl[r].lo1, tbl[r].hi1);
      if (tbl[r].clr != 2'b00) begin
        to_cyc(WIN*r + 100);
        fail_clr = tbl[r].clr;
        @(negedge clk);
        fail_clr = '0;
      end
      to_cyc(WIN*(r+1) - 1);
      chk("tbl vld before we", cnt_vld, 0);
      to_cyc(WIN*(r+1));
      chk("tbl vld", cnt_vld, 1);
      if (tbl[r].chk_cnt) begin
        chk("tbl cnt0", cnt_out[8:0], tbl[r].c0);
        chk("tbl cnt1", cnt_out[17:9], tbl[r].c1);
      end
      chk("tbl fail", fail, tbl[r].fl);
      to_cyc(WIN*(r+1) + 1);
      chk("tbl fail_any", fail_any, |tbl[r].fl);
      chk("tbl vld low", cnt_vld, 0);
    end

    // stopped clock: two bad windows, then clear collides with a set at WE
    fail_clr = 2'b11; en = 2'b01; set_th(24, 40, 24, 40); half[0] = 0;
    @(negedge clk);
    fail_clr = '0;
    chk("clr non-we fail", fail, 0);
    @(negedge clk);
    chk("clr non-we fail_any", fail_any, 0);
    to_cyc(WIN*14);
    chk("stop we14 fail", fail, 2'b00);
    to_cyc(WIN*15 - 1);
    chk("stop pre-we15 fail", fail, 2'b00);
    to_cyc(WIN*15);
    chk("stop we15 fail", fail, 2'b01);
    chk("stop we15 fail_any", fail_any, 0);
    to_cyc(WIN*15 + 1);
    chk("stop we15+1 fail_any", fail_any, 1);
    to_cyc(WIN*16 - 1);
    fail_clr = 2'b01;
    @(negedge clk);
    fail_clr = '0;
    chk("set wins over clr", fail, 2'b01);

    // reset mid-window: outputs clear, first window is reported but not judged
    to_cyc(WIN*16 + 40);
    do_reset(3);
    to_cyc(WIN);
    chk("warm vld", cnt_vld, 1);
    chk("warm cnt0", cnt_out[8:0], 0);
    chk("warm fail", fail, 0);
    to_cyc(WIN*2);
    chk("post-warm bad1 fail", fail, 0);
    chk("sat cnt", s_cnt, 63);
    chk("sat vld", s_vld, 1);
    chk("sat fail", s_fail, 0);
    to_cyc(WIN*3);
    chk("post-warm bad2 fail", fail, 2'b01);
    chk("sat cnt 2", s_cnt, 63);
    to_cyc(WIN*3 + 1);
    chk("post-warm fail_any", fail_any, 1);
    to_cyc(WIN*3 + 50);
    fail_clr = 2'b01;
    @(negedge clk);
    fail_clr = '0;
    chk("clr mid fail", fail, 0);
    @(negedge clk);
    chk("clr mid fail_any", fail_any, 0);

    // randomized windows against the model
    for (int i = 0; i < NCH; i++) half[i] = $urandom_range(0, 8);
    @(negedge clk);
    do_reset(3);
    for (int w = 0; w < 30; w++) begin
      int unsigned base, mid;
      base = WIN*w;
      to_cyc(base + 1);
      en = 2'($urandom_range(0, 3));
      set_th($urandom_range(0, 70), $urandom_range(0, 130),
             $urandom_range(0, 70), $urandom_range(0, 130));
      mid = $urandom_range(2, WIN - 3);
      to_cyc(base + mid);
      if ($urandom_range(0, 3) == 0) half[$urandom_range(0, NCH-1)] = $urandom_range(0, 8);
      if ($urandom_range(0, 2) == 0) begin
        fail_clr = 2'($urandom_range(1, 3));
        @(negedge clk);
        fail_clr = '0;
      end
      to_cyc(base + WIN);
      chk("rnd vld", cnt_vld, m_vld);
      chk("rnd cnt_out", cnt_out, {9'(m_rep[1]), 9'(m_rep[0])});
      chk("rnd fail", fail, m_fail);
      chk("rnd fail_any", fail_any, m_any);
      chk("rnd rst_req", rst_req, m_rreq);
      to_cyc(base + WIN + 1);
      chk("rnd vld low", cnt_vld, m_vld);
      chk("rnd fail_any+1", fail_any, m_any);
      chk("rnd rst_req+1", rst_req, m_rreq);
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
